three_bit_odd_parity_checker_fsm: RTL and testbench

- Downstream neighbour of the three-bit odd parity generator FSM.
- Consumes the generator's ASCII character stream, one character per accepted cycle, in 4-character frames: data bit 2, bit 1, bit 0 (MSB first, each '0' or '1'), then the parity character '0' or '1'.
- After each frame, emits an ASCII status character and the decoded 3-bit word, and keeps running frame and error counts for bench or display readout.

---
 rtl/three_bit_odd_parity_checker_fsm_pkg.sv | 24 ++
 rtl/three_bit_odd_parity_checker_fsm_sat_counter.sv | 20 ++
 rtl/three_bit_odd_parity_checker_fsm.sv | 117 +++++++++++
 tb/tb_three_bit_odd_parity_checker_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/three_bit_odd_parity_checker_fsm_pkg.sv
// Shared constants for the 3-bit odd parity generator/checker pair.
// ASCII character codes, status codes and the frame-position encoding.
package three_bit_odd_parity_checker_fsm_pkg;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_1   = 8'h31;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] ST_OK  = 8'h4B;
    localparam logic [7:0] ST_ERR = 8'h45;
    localparam logic [7:0] ST_BAD = 8'h58;

    // Frame position; shared so that generator and checker line up.
    typedef enum logic [1:0] {
        S_B2 = 2'd0,
        S_B1 = 2'd1,
        S_B0 = 2'd2,
        S_P  = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [7:0] c);
        return (c == CH_0) || (c == CH_1);
    endfunction

endpackage

// File: rtl/three_bit_odd_parity_checker_fsm_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Ports: clk, reset (async active-low), inc, value[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/three_bit_odd_parity_checker_fsm.sv
// Checks 4-character ASCII frames (3 data bits + odd parity char).
// Ports: clk, reset (async active-low), in_valid, i[7:0] -> o[7:0]
//   status, out_valid pulse, data_out[2:0], frame_cnt, err_cnt.
module three_bit_odd_parity_checker_fsm
    import three_bit_odd_parity_checker_fsm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       i,
    output logic [7:0]       o,
    output logic             out_valid,
    output logic [2:0]       data_out,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t     state, state_n;
    logic       par, par_n;
    logic [2:0] sr, sr_n;
    logic       bad, bad_n;
    logic [7:0] o_n;
    logic [2:0] d_n;
    logic       ov_n;
    logic       done;
    logic       err;
    logic       legal;
    logic       b;
    logic [7:0] st;

    // Illegal characters contribute 0 to data and parity.
    assign legal = is_legal(i);
    assign b     = (i == CH_1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_B2;
            par       <= 1'b0;
            sr        <= 3'b000;
            bad       <= 1'b0;
            o         <= CH_SP;
            data_out  <= 3'b000;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            par       <= par_n;
            sr        <= sr_n;
            bad       <= bad_n;
            o         <= o_n;
            data_out  <= d_n;
            out_valid <= ov_n;
        end
    end

    always_comb begin
        // X wins over the parity result; overlap is intended.
        priority case (1'b1)
            (bad || !legal): st = ST_BAD;
            (par ^ b):       st = ST_OK;
            default:         st = ST_ERR;
        endcase
    end

    always_comb begin
        state_n = state;
        par_n   = par;
        sr_n    = sr;
        bad_n   = bad;
        o_n     = o;
        d_n     = data_out;
        ov_n    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        if (in_valid) begin
            unique case (state)
                S_B2: begin
                    sr_n    = {2'b00, b};
                    par_n   = b;
                    bad_n   = !legal;
                    state_n = S_B1;
                end
                S_B1, S_B0: begin
                    sr_n    = {sr[1:0], b};
                    par_n   = par ^ b;
                    bad_n   = bad | !legal;
                    state_n = (state == S_B1) ? S_B0 : S_P;
                end
                S_P: begin
                    o_n     = st;
                    d_n     = sr;
                    ov_n    = 1'b1;
                    done    = 1'b1;
                    err     = (st != ST_OK);
                    state_n = S_B2;
                end
                default: state_n = S_B2;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (done),
        .value (frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err),
        .value (err_cnt)
    );

endmodule

// File: tb/tb_three_bit_odd_parity_checker_fsm.sv
// Bench for the parity checker: directed frames plus random stream.
// Two DUTs (CNT_W 8 and 2) share stimulus; a frame-level model predicts.
module tb_three_bit_odd_parity_checker_fsm;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] i;
    logic [7:0] o, o2;
    logic       out_valid, out_valid2;
    logic [2:0] data_out, data_out2;
    logic [7:0] frame_cnt, err_cnt;
    logic [1:0] frame_cnt2, err_cnt2;

    int checks = 0;
    int failures = 0;

    byte        q[$];
    logic [7:0] e_o;
    logic [2:0] e_d;
    logic       e_ov;
    int         nf, ne;

    three_bit_odd_parity_checker_fsm #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .i         (i),
        .o         (o),
        .out_valid (out_valid),
        .data_out  (data_out),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    three_bit_odd_parity_checker_fsm #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .i         (i),
        .o         (o2),
        .out_valid (out_valid2),
        .data_out  (data_out2),
        .frame_cnt (frame_cnt2),
        .err_cnt   (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("o", 32'(o), 32'(e_o));
        chk("data_out", 32'(data_out), 32'(e_d));
        chk("frame_cnt", 32'(frame_cnt), sat(nf, 255));
        chk("err_cnt", 32'(err_cnt), sat(ne, 255));
        chk("out_valid2", 32'(out_valid2), 32'(e_ov));
        chk("o2", 32'(o2), 32'(e_o));
        chk("frame_cnt2", 32'(frame_cnt2), sat(nf, 3));
        chk("err_cnt2", 32'(err_cnt2), sat(ne, 3));
    endtask

    // Frame-level reference: count ones, flag anything not '0'/'1'.
    task automatic model_frame();
        int  ones;
        bit  bd;
        ones = 0;
        bd   = 0;
        e_d  = 3'b000;
        for (int k = 0; k < 4; k++) begin
            if (q[k] == "1") begin
                ones++;
                if (k < 3) e_d[2-k] = 1'b1;
            end else if (q[k] != "0") begin
                bd = 1;
            end
        end
        if (bd) e_o = "X";
        else if (ones % 2 == 1) e_o = "K";
        else e_o = "E";
        nf++;
        if (e_o != "K") ne++;
        q.delete();
    endtask

    task automatic step(input logic v, input logic [7:0] c);
        @(negedge clk);
        in_valid = v;
        i = c;
        @(posedge clk);
        #1;
        e_ov = 1'b0;
        if (v) begin
            q.push_back(c);
            if (q.size() == 4) begin
                model_frame();
                e_ov = 1'b1;
            end
        end
        check_all();
    endtask

    task automatic send(input string s);
        for (int k = 0; k < s.len(); k++) step(1'b1, s[k]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        e_o = " ";
        e_d = 3'b000;
        e_ov = 1'b0;
        nf = 0;
        ne = 0;
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        i = 8'h00;
        e_o = " ";
        e_d = 3'b000;
        e_ov = 1'b0;
        nf = 0;
        ne = 0;
        #3;
        do_reset();
        step(1'b0, 8'h00);

        send("0100");
        send("1111");
        send("0000");
        send("1110");
        step(1'b0, 8'h00);

        send("0 10");
        send("0011");

        step(1'b1, "1");
        repeat (5) step(1'b0, "1");
        step(1'b1, "0");
        repeat (5) step(1'b0, "0");
        step(1'b1, "1");
        repeat (5) step(1'b0, "0");
        step(1'b1, "1");
        step(1'b0, 8'h00);

        do_reset();
        send("11");
        do_reset();
        send("1001");
        step(1'b0, 8'h00);

        repeat (5) send("0001");
        step(1'b0, 8'h00);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] c;
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) c = "0";
            else if (r < 8) c = "1";
            else c = 8'($urandom);
            step(($urandom_range(0, 3) != 0), c);
        end

        do_reset();
        for (int n = 0; n < 40; n++) send("1000");
        step(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
